// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one line-wide data memory between the instruction side (port 0)
// and the data cache (port 1). Optional macro ARB_ROUND_ROBIN_EN selects round-robin ties.
module mem_arbiter #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_ack_o,
    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_ack_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

    state_e              state_q, state_d;
    logic                write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   rdata0_q, rdata1_q;
    logic                any_req;
    logic                winner;  // 1 selects port 1
    logic                issue;

    assign any_req = m0_enable_i | m1_enable_i;
    assign issue   = (state_q == StIdle) && any_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic prio_q;  // port that wins the next tie

    always_comb begin
        winner = m1_enable_i;
        if (m0_enable_i && m1_enable_i) begin
            winner = prio_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= 1'b1;
        end else if (issue) begin
            prio_q <= ~winner;
        end
    end
`else
    always_comb begin
        winner = m1_enable_i;
    end
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a grant always runs until the memory acks
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = winner ? StGrant1 : StGrant0;
                end
            end
            StGrant0, StGrant1: begin
                if (mem_ack_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (issue) begin
            write_q <= winner ? m1_write_i : m0_write_i;
            addr_q  <= winner ? m1_addr_i : m0_addr_i;
            data_q  <= winner ? m1_data_i : m0_data_i;
        end
    end

    // Read data is held until the owner's next ack; the data cache consumes it a cycle late
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (state_q == StGrant0 && mem_ack_i) begin
                rdata0_q <= mem_data_i;
            end
            if (state_q == StGrant1 && mem_ack_i) begin
                rdata1_q <= mem_data_i;
            end
        end
    end

    // Outputs
    always_comb begin
        mem_enable_o = (state_q != StIdle);
        mem_write_o  = write_q;
        mem_addr_o   = addr_q;
        mem_data_o   = data_q;
        m0_ack_o     = (state_q == StGrant0) && mem_ack_i;
        m1_ack_o     = (state_q == StGrant1) && mem_ack_i;
        m0_data_o    = m0_ack_o ? mem_data_i : rdata0_q;
        m1_data_o    = m1_ack_o ? mem_data_i : rdata1_q;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single 256-bit data memory between the instruction-side requester (port 0) and the data cache (port 1). It sits between both caches' memory interfaces and the data memory, serialises their line transfers, latches each port's command for the duration of the transfer, and routes acknowledge and read data back to the owner. Each requester sees the same enable/write/addr/data/ack protocol it would see from the memory directly.

## Interface
- DATA_W, 256, memory line width in bits
- ADDR_W, 32, byte address width
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; synchronous, active-high
- m0_enable_i  in  1  port 0 request; held high until m0_ack_o
- m0_write_i  in  1  port 0 write (1) / read (0)
- m0_addr_i  in  ADDR_W  port 0 line address
- m0_data_i  in  DATA_W  port 0 write data
- m0_data_o  out  DATA_W  port 0 read data
- m0_ack_o  out  1  port 0 completion pulse
- m1_enable_i, m1_write_i, m1_addr_i, m1_data_i, m1_data_o, m1_ack_o: same as port 0, for the data cache
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  memory write
- mem_addr_o  out  ADDR_W  memory address
- mem_data_o  out  DATA_W  memory write data
- mem_data_i  in  DATA_W  memory read data
- mem_ack_i  in  1  memory completion pulse, one cycle

## Operation
- FSM states: IDLE, GRANT0, GRANT1.
- IDLE, no enable high: stay in IDLE.
- IDLE, any enable high: pick a winner. At the edge, copy the winner's write/addr/data into command registers, set mem_enable_o=1 and enter GRANTn.
- GRANTn:
  - mem_enable_o, mem_write_o, mem_addr_o and mem_data_o are driven from the command registers.
  - Requester inputs are ignored, including a deasserted enable.
  - The transfer always runs to completion.
- GRANTn with mem_ack_i=1:
  - mn_ack_o=1 combinationally in the same cycle.
  - On that edge: latch mem_data_i into port n's read-data register, set mem_enable_o=0, return to IDLE.
- mn_data_o = (grant==n && mem_ack_i) ? mem_data_i : rdata_n_q.
  - Read data is valid in the ack cycle.
  - It is held until port n's next ack, because the data cache consumes the line one cycle after ack.
  - Write acks also update rdata_n_q; requesters ignore the value.
- mn_ack_o is never high for the non-granted port. Both acks are 0 outside GRANT states.
- Stray mem_ack_i in IDLE is ignored, and no register changes.
- A requester may keep its enable high after ack to start a back-to-back transfer (data-cache writeback followed by refill). That transfer re-arbitrates in IDLE.
- Winner selection: see Configuration.

## Timing
- Reset values:
  - State: IDLE.
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
  - m0_ack_o=m1_ack_o=0, m0_data_o=m1_data_o=0.
  - Priority pointer: port 1.
- Reset asserted mid-transfer: outputs return to reset values the following cycle and the transfer is abandoned. The requester is never acked for it.
- Latency, enable high to mem_enable_o high: 1 cycle (enable seen in IDLE at edge k, mem_enable_o high from cycle k+1).
- Ack to next grant: there is one IDLE cycle between mem_ack_i and the next mem_enable_o. Minimum re-request turnaround is 2 cycles.
- Arbiter adds no latency between mem_ack_i and mn_ack_o.
- Simultaneous requests in IDLE: resolved by the priority rule. The loser's enable stays high, and it is granted at the next IDLE.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Round-robin arbitration with a 1-bit last-grant pointer, updated when the grant is issued.
  - On a tie in IDLE, the port not granted last wins.
  - A continuously requesting port waits at most one transfer.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority; port 1 (data cache) always wins a tie.
  - The pointer register is not built.

## Test plan
- Reset, then m1 reads addr 0x0000_0400; memory acks after 10 cycles with data 0xA5..A5 -> mem_enable_o high 1 cycle after request, mem_addr_o=0x400, mem_write_o=0, m1_ack_o pulses with ack, m1_data_o=0xA5..A5 in ack cycle and still the cycle after.
- m0 and m1 both raise enable in the same cycle, and both hold enable high through several transfers:
  - With ARB_ROUND_ROBIN_EN, grants alternate 1,0,1,0.
  - Without it, m1 wins every tie and m0 is granted only in IDLE cycles where m1 is low.
- m1 writeback to 0x800 with data 0x1234.., keeping enable high with write=0 and addr 0xC00 after ack -> the write completes, one IDLE cycle follows, then a read of 0xC00 is issued with no lost ack.
- m0 drops enable and changes addr during GRANT0 -> mem_addr_o stays at the captured value, the transfer completes, and m0_ack_o pulses once.
- rst_i asserted 3 cycles into a GRANT1 transfer -> the next cycle shows mem_enable_o=0, state IDLE, and both data outputs 0. A late mem_ack_i produces no m*_ack_o.
